// File: rtl/prog_timer.sv
// Programmable interval timer: one-shot or periodic, with optional clock prescaler.
// Build option: define PROG_TIMER_PRESCALE_EN to include the prescaler; without it
// every enabled cycle advances the count and the prescale port is ignored.
module prog_timer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PSC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     final_value,
  input  logic [PSC_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]     count,
  output logic                 tick,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;

  logic             active_c;
  logic             strobe_c;
  logic             advance_c;
  logic             terminal_c;

  // A timer in PAUSE is still armed; enable alone decides whether time passes,
  // so the edge that leaves PAUSE already counts and a pause of N cycles costs N.
  assign active_c   = (state_q != ST_IDLE);
  assign advance_c  = active_c & enable & strobe_c & ~stop & ~start;
  assign terminal_c = (count_q == shadow_q);

`ifdef PROG_TIMER_PRESCALE_EN
  logic [PSC_WIDTH-1:0] psc_q, psc_d;

  assign strobe_c = (psc_q == prescale);

  // Prescaler: counts 0..prescale while the timer is armed and enabled.
  always_comb begin
    psc_d = psc_q;
    if (stop || start) begin
      psc_d = '0;
    end else if (active_c && enable) begin
      psc_d = strobe_c ? '0 : psc_q + PSC_WIDTH'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  logic unused_prescale;

  assign strobe_c        = 1'b1;
  assign unused_prescale = ^prescale;
`endif

  // Next-state, count, shadow and tick logic; stop outranks start outranks counting.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    busy_d   = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (start) begin
      state_d  = ST_RUN;
      count_d  = '0;
      shadow_d = final_value;
      mode_d   = mode;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          count_d = '0;
        end
        ST_RUN, ST_PAUSE: begin
          state_d = enable ? ST_RUN : ST_PAUSE;
          if (advance_c) begin
            if (terminal_c) begin
              count_d = '0;
              tick_d  = 1'b1;
              if (mode_q) begin
                shadow_d = final_value;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign busy  = busy_q;

endmodule
